// File: rtl/alu_resp_unit.sv
// alu_resp_unit: handshaked ALU responder.
// Requests are captured into stage S1. The ALU result is computed
// combinationally from S1 and pushed into a small in-order response FIFO.
// The FIFO exerts full backpressure on the request side.
//
// Handshake rule: a transfer happens on a rising edge where valid && ready.
// - A producer holds valid and its payload stable until the transfer.
// - ready never depends on valid on the same channel.
// - Response payload is held stable while rsp_valid && !rsp_ready.
module alu_resp_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [15:0]      op_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = WIDTH + 2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Stage S1
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;

    // ALU outputs
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_err;

    // Response FIFO entries are packed as {res, zero, err}
    logic [ENT_W-1:0] q_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ENT_W-1:0] head;

    logic pop;
    logic push;
    logic slot_free;
    logic s1_advance;
    logic accept;

    // Circular pointer advance that also works for non-power-of-two depths
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // A slot counts as free when the head leaves on the same edge,
    // so a full queue still takes one entry per cycle while draining.
    assign pop        = rsp_valid && rsp_ready;
    assign slot_free  = (count < CNT_W'(DEPTH)) || pop;
    assign s1_advance = s1_valid && slot_free;
    assign push       = s1_advance;
    assign req_ready  = !s1_valid || s1_advance;
    assign accept     = req_valid && req_ready;

    // ALU on the S1 operands; illegal opcodes yield result 0 with err set
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (s1_op)
            OP_AND:  alu_res = s1_a & s1_b;
            OP_OR:   alu_res = s1_a | s1_b;
            OP_ADD:  alu_res = s1_a + s1_b;
            OP_SUB:  alu_res = s1_a - s1_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            default: alu_err = 1'b1;
        endcase
        alu_zero = (alu_res == '0);
    end

    // S1 capture: load on accept, drain into the queue on advance
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= req_a;
                s1_b     <= req_b;
                s1_op    <= req_op;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Queue storage; contents are don't-care while the slot is empty
    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= {alu_res, alu_zero, alu_err};
        end
    end

    // Queue pointers, occupancy and the completed-response counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            op_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                op_count <= op_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head of queue drives the response; all-zero while empty
    always_comb begin
        head      = q_mem[rd_ptr];
        rsp_valid = (count != '0);
        rsp_res   = '0;
        rsp_zero  = 1'b0;
        rsp_err   = 1'b0;
        if (rsp_valid) begin
            rsp_res  = head[ENT_W-1:2];
            rsp_zero = head[1];
            rsp_err  = head[0];
        end
    end

endmodule

// File: tb/tb_alu_resp_unit.sv
// tb_alu_resp_unit: directed vectors with hand-computed results, checked
// through an in-order expected queue of {res, zero, err}.
module tb_alu_resp_unit;

  localparam int W = 32;
  localparam logic [33:0] NO_EXP = '1; // res != 0 with zero=1: never legal

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [33:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic [2:0]    req_op = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_res;
  logic          rsp_zero;
  logic          rsp_err;
  logic [15:0]   op_count;

  vec_t          stim_q[$];
  logic [33:0]   exp_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            first_acc = -1;
  int            first_rsp = -1;
  int            last_rsp = -1;
  int            n_acc = 0;

  alu_resp_unit #(.WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] res, input logic z, input logic e);
    vec_t v;
    v.a = a;
    v.b = b;
    v.op = op;
    v.exp = {res, z, e};
    stim_q.push_back(v);
  endtask

  task automatic mark_clear();
    first_acc = -1;
    first_rsp = -1;
    last_rsp = -1;
    n_acc = 0;
  endtask

  // One cycle: drive just after a posedge, observe at negedge, end #1 after next posedge
  task automatic step();
    logic [33:0] e;
    if (stim_q.size() != 0) begin
      req_valid = 1'b1;
      req_a = stim_q[0].a;
      req_b = stim_q[0].b;
      req_op = stim_q[0].op;
    end else begin
      req_valid = 1'b0;
    end
    @(negedge clk);
    if (rsp_valid && rsp_ready) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : NO_EXP;
      check("rsp", {30'd0, rsp_res, rsp_zero, rsp_err}, {30'd0, e});
      if (first_rsp < 0) first_rsp = cyc;
      last_rsp = cyc;
    end
    if (req_valid && req_ready) begin
      exp_q.push_back(stim_q[0].exp);
      void'(stim_q.pop_front());
      if (first_acc < 0) first_acc = cyc;
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (stim_q.size() != 0 || exp_q.size() != 0)
      check("timeout_pending", 64'(stim_q.size() + exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    stim_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // reset state
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_res", rsp_res, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_op_count", op_count, 0);

    // basic arithmetic, back-to-back
    rsp_ready = 1'b1;
    mark_clear();
    load(32'd5, 32'd2, 3'b010, 32'd7, 1'b0, 1'b0);
    load(32'd7, 32'hFFFF_FFFD, 3'b011, 32'd10, 1'b0, 1'b0);
    load(32'h007F_FFFF, 32'h8780_7C1C, 3'b000, 32'h0000_7C1C, 1'b0, 1'b0);
    run(20);
    check("basic_latency", 64'(first_rsp - first_acc), 64'd2);
    check("basic_consec", 64'(last_rsp - first_rsp), 64'd2);

    // zero flag and ordering
    load(32'd9, 32'd9, 3'b011, 32'd0, 1'b1, 1'b0);
    load(32'd1, 32'd1, 3'b010, 32'd2, 1'b0, 1'b0);
    run(20);

    // signed SLT
    load(32'd2, 32'd4, 3'b111, 32'd1, 1'b0, 1'b0);
    load(32'hFFFF_FFFA, 32'd2, 3'b111, 32'd1, 1'b0, 1'b0);
    load(32'd14, 32'd2, 3'b111, 32'd0, 1'b1, 1'b0);
    load(32'h8000_0000, 32'd0, 3'b111, 32'd1, 1'b0, 1'b0);
    run(20);

    // illegal opcode then legal ADD
    load(32'd3, 32'd4, 3'b100, 32'd0, 1'b1, 1'b1);
    load(32'd3, 32'd4, 3'b010, 32'd7, 1'b0, 1'b0);
    run(20);

    // backpressure: 5 offered with rsp_ready low
    do_reset();
    rsp_ready = 1'b0;
    mark_clear();
    load(32'd1, 32'd1, 3'b010, 32'd2, 1'b0, 1'b0);
    load(32'd10, 32'd3, 3'b011, 32'd7, 1'b0, 1'b0);
    load(32'hF0, 32'h0F, 3'b001, 32'hFF, 1'b0, 1'b0);
    load(32'd3, 32'd3, 3'b011, 32'd0, 1'b1, 1'b0);
    load(32'd100, 32'd23, 3'b010, 32'd123, 1'b0, 1'b0);
    repeat (6) step();
    check("bp_accepted", 64'(n_acc), 64'd3);
    check("bp_req_ready_low", req_ready, 0);
    check("bp_queue_held", rsp_valid, 1);
    rsp_ready = 1'b1;
    #1;
    check("bp_recover_ready", req_ready, 1);
    first_rsp = -1;
    last_rsp = -1;
    run(30);
    check("bp_drain_consec", 64'(last_rsp - first_rsp), 64'd4);
    check("bp_op_count", op_count, 5);

    // reset mid-operation with a full pipeline and req_valid high
    rsp_ready = 1'b0;
    load(32'd11, 32'd1, 3'b010, 32'd12, 1'b0, 1'b0);
    load(32'd12, 32'd1, 3'b010, 32'd13, 1'b0, 1'b0);
    load(32'd13, 32'd1, 3'b010, 32'd14, 1'b0, 1'b0);
    repeat (4) step();
    check("prerst_full", rsp_valid, 1);
    req_valid = 1'b1;
    req_a = 32'd40;
    req_b = 32'd2;
    req_op = 3'b010;
    do_reset();
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_op_count", op_count, 0);
    check("mid_rst_req_ready", req_ready, 1);
    rsp_ready = 1'b1;
    repeat (4) step();
    check("post_rst_no_rsp", op_count, 0);
    mark_clear();
    load(32'd1, 32'd2, 3'b010, 32'd3, 1'b0, 1'b0);
    run(20);
    check("post_rst_latency", 64'(first_rsp - first_acc), 64'd2);
    check("post_rst_op_count", op_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_resp_unit.md
# alu_resp_unit

Handshaked, pipelined ALU execution unit: the responder side of the operand/opcode/result interface used to exercise the datapath ALU. It accepts requests (A, B, operation) over a valid/ready channel, computes the result one stage later, and returns result, zero and error flags through a small response queue with full backpressure. It replaces direct combinational ALU access wherever producer and consumer run decoupled, such as the multi-cycle datapath and the self-checking bench harness.

## Interface
- WIDTH, 32: operand and result width.
- DEPTH, 2: response queue depth in entries (≥1).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept the request this cycle.
- req_a  in  WIDTH  operand A (signed).
- req_b  in  WIDTH  operand B (signed).
- req_op  in  3  operation: 000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT; all other codes are illegal.
- rsp_valid  out  1  response present at queue head.
- rsp_ready  in  1  consumer takes the response.
- rsp_res  out  WIDTH  result.
- rsp_zero  out  1  1 when rsp_res == 0.
- rsp_err  out  1  1 when the request carried an illegal opcode.
- op_count  out  16  count of completed response handshakes.

## Operation
- Request accepted when req_valid && req_ready at a rising edge. Operands and opcode are captured into stage register S1, and s1_valid is set.
- ALU function is combinational from S1:
  - AND and OR are bitwise.
  - ADD is A+B and SUB is A−B, both modulo 2^WIDTH, with no overflow flag.
  - SLT returns 1 if signed A < signed B, otherwise 0, zero-extended.
  - Illegal opcode: result 0, err 1, zero 1.
- S1 advances into the response queue when s1_valid and the queue has a free slot. A slot counts as free if count < DEPTH, or if the head is popped in the same cycle (rsp_valid && rsp_ready).
- req_ready = !s1_valid || s1_advance. Combinational, and does not depend on req_valid.
- The response queue is a FIFO of {res, zero, err}.
  - rsp_valid = (count != 0).
  - rsp_* reflect the head entry.
  - When the queue is empty, rsp_res = 0, rsp_zero = 0 and rsp_err = 0.
- Simultaneous push and pop on a full queue is legal; count is unchanged.
- Simultaneous push and pop on an empty queue is impossible, because the pop requires rsp_valid.
- Responses leave in strict request order. No request is dropped or duplicated.
- op_count increments on every rsp_valid && rsp_ready edge. It wraps from 16'hFFFF to 0.
- Response outputs are held stable while rsp_valid && !rsp_ready.

## Timing
- Reset (rst == 0 at an edge):
  - s1_valid = 0, queue count = 0, read/write pointers = 0, op_count = 0.
  - Resulting outputs: rsp_valid = 0, rsp_res = 0, rsp_zero = 0, rsp_err = 0, req_ready = 1.
  - Reset overrides any handshake in the same cycle. In-flight requests and queued responses are discarded, not completed.
- Latency:
  - Request accepted at edge N reaches S1 after N.
  - It is pushed into the queue at edge N+1, so rsp_valid is high after N+1 when the queue was empty.
  - Minimum request-to-response latency: 2 cycles.
- Throughput: 1 request per cycle sustained while rsp_ready stays high.
- Backpressure: with rsp_ready held low, exactly DEPTH+1 requests are accepted (DEPTH queued, 1 in S1), after which req_ready stays low.
- Recovery: the first pop frees a slot. S1 advances on that same edge, so req_ready is high in the same cycle the pop is presented.

## Test plan
- Basic arithmetic, back-to-back requests with rsp_ready = 1:
  - ADD 5,2 -> res 7, zero 0.
  - SUB 7,−3 -> res 10.
  - AND 32'h007FFFFF, 32'h87807C1C -> 32'h00007C1C.
  - Responses appear on consecutive cycles starting 2 cycles after the first accept.
- Zero and ordering: SUB 9,9 followed by ADD 1,1 -> first response res 0, zero 1; then res 2, zero 0, in that order.
- SLT, signed: SLT 2,4 -> 1; SLT −6,2 -> 1; SLT 14,2 -> 0; SLT 32'h80000000,0 -> 1.
- Backpressure: rsp_ready = 0 with 5 requests offered.
  - Exactly 3 accepted, then req_ready low.
  - Raising rsp_ready drains all 5 in order, one per cycle.
  - op_count = 5 at the end.
- Illegal opcode: op 3'b100 with A = 3, B = 4 -> res 0, zero 1, err 1. A following legal ADD 3,4 -> res 7, err 0.
- Reset mid-operation:
  - Fill the queue, then assert rst low for 1 cycle with req_valid high.
  - Next cycle: rsp_valid 0, op_count 0, req_ready 1, and none of the pre-reset responses ever appear.
  - A new ADD 1,2 returns 3 after 2 cycles.
